// File: rtl/inert_seq.sv
// Power-up and interrupt sequencer for the iNEMO inertial sensor: POR wait, two setup writes, then yaw-rate reads per INT.
// Optional heading integrator is enabled by defining INERT_INTEG_EN.
module inert_seq #(
    parameter logic [15:0] POR_WAIT = 16'hFFFF,
    parameter int unsigned HEAD_W   = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              int_i,
    input  logic              done_i,
    input  logic [15:0]       rd_data_i,
    output logic              wrt_o,
    output logic [15:0]       cmd_o,
    output logic              rdy_o,
    output logic              vld_o,
    output logic [15:0]       yaw_rt_o,
    output logic [HEAD_W-1:0] heading_o
);

    localparam logic [15:0] CMD_INT1_CTRL = 16'h0D02;
    localparam logic [15:0] CMD_CTRL2_G   = 16'h1160;
    localparam logic [15:0] CMD_RD_YAW_LO = 16'hA600;
    localparam logic [15:0] CMD_RD_YAW_HI = 16'hA700;

    typedef enum logic [2:0] {
        PWAIT,
        W1,
        W2,
        IDLE,
        RL,
        RH
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic        int_meta_q;
    logic        int_s_q;
    logic [7:0]  lo_q;
    logic        wrt_q;
    logic [15:0] cmd_q;
    logic        rdy_q;
    logic        vld_q;
    logic [15:0] yaw_q;

    // Only the register byte of the returned word carries data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data_i[15:8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
        end else begin
            int_meta_q <= int_i;
            int_s_q    <= int_meta_q;
        end
    end

    // Outputs are registered here so wrt is a clean single-cycle pulse with cmd updated alongside it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PWAIT;
            timer_q <= 16'h0000;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            yaw_q   <= 16'h0000;
            lo_q    <= 8'h00;
        end else begin
            wrt_q <= 1'b0;
            vld_q <= 1'b0;
            case (state_q)
                PWAIT: begin
                    if (timer_q == POR_WAIT) begin
                        wrt_q   <= 1'b1;
                        cmd_q   <= CMD_INT1_CTRL;
                        state_q <= W1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                W1: begin
                    if (done_i) begin
                        wrt_q   <= 1'b1;
                        cmd_q   <= CMD_CTRL2_G;
                        state_q <= W2;
                    end
                end
                W2: begin
                    if (done_i) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (int_s_q) begin
                        wrt_q   <= 1'b1;
                        cmd_q   <= CMD_RD_YAW_LO;
                        state_q <= RL;
                    end
                end
                RL: begin
                    if (done_i) begin
                        lo_q    <= rd_data_i[7:0];
                        wrt_q   <= 1'b1;
                        cmd_q   <= CMD_RD_YAW_HI;
                        state_q <= RH;
                    end
                end
                RH: begin
                    if (done_i) begin
                        yaw_q   <= {rd_data_i[7:0], lo_q};
                        vld_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= PWAIT;
            endcase
        end
    end

    assign wrt_o    = wrt_q;
    assign cmd_o    = cmd_q;
    assign rdy_o    = rdy_q;
    assign vld_o    = vld_q;
    assign yaw_rt_o = yaw_q;

`ifdef INERT_INTEG_EN
    // Heading is the top HEAD_W bits of a free-wrapping 27-bit sum of yaw samples.
    logic [26:0] acc_q;
    logic [26:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (vld_q) begin
            acc_d = acc_q + {{11{yaw_q[15]}}, yaw_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= 27'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign heading_o = acc_q[26 -: HEAD_W];
`else
    assign heading_o = {HEAD_W{1'b0}};
`endif

endmodule

// File: tb/tb_inert_seq.sv
// Self-checking bench for inert_seq: scripted SPI master answering 32 clocks after each wrt,
// directed init/reset sequences, a vector table and randomized yaw samples against a reference model.
module tb_inert_seq;

    localparam logic [15:0] PW      = 16'd100;
    localparam int          HW      = 27;
    localparam int          SPI_LAT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          intr;
    logic          done;
    logic [15:0]   rdData;
    logic          wrt;
    logic [15:0]   cmd;
    logic          rdy;
    logic          vld;
    logic [15:0]   yawRt;
    logic [HW-1:0] heading;

    always #5 clk = ~clk;

    inert_seq #(
        .POR_WAIT (PW),
        .HEAD_W   (HW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .int_i     (intr),
        .done_i    (done),
        .rd_data_i (rdData),
        .wrt_o     (wrt),
        .cmd_o     (cmd),
        .rdy_o     (rdy),
        .vld_o     (vld),
        .yaw_rt_o  (yawRt),
        .heading_o (heading)
    );

    int checks = 0;
    int errors = 0;
    int wrtCount = 0;
    int vldCount = 0;

    // Pulse counters sampled mid-cycle so they see settled register outputs.
    always @(negedge clk) begin
        if (wrt) wrtCount++;
        if (vld) vldCount++;
    end

    // Reference model: last yaw word and the running 27-bit heading sum.
    logic [15:0] modelYaw;
    logic [26:0] modelAcc;

    function automatic logic [HW-1:0] expHeading();
`ifdef INERT_INTEG_EN
        return modelAcc[26 -: HW];
`else
        return '0;
`endif
    endfunction

    task automatic modelSample(input logic [7:0] lo, input logic [7:0] hi);
        int sum;
        modelYaw = {hi, lo};
        sum = int'(modelAcc) + int'($signed(modelYaw));
        modelAcc = sum[26:0];
    endtask

    task automatic modelReset();
        modelYaw = 16'h0000;
        modelAcc = 27'd0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitWrt(input string name, input int maxC, output int n);
        n = 0;
        while (!wrt && n < maxC) begin
            tick(1);
            n++;
        end
        checkOutput({name, " wrt seen"}, {31'd0, wrt}, 32'd1);
    endtask

    // One SPI transaction: expect wrt with expCmd, hold for the master latency, answer with rsp.
    task automatic doTxn(input string name, input logic [15:0] expCmd, input logic [15:0] rsp,
                         input bit clearInt);
        int n;
        waitWrt(name, 400, n);
        checkOutput({name, " cmd"}, {16'd0, cmd}, {16'd0, expCmd});
        tick(1);
        checkOutput({name, " wrt width"}, {31'd0, wrt}, 32'd0);
        tick(SPI_LAT - 2);
        checkOutput({name, " cmd stable"}, {16'd0, cmd}, {16'd0, expCmd});
        done   = 1'b1;
        rdData = rsp;
        if (clearInt) intr = 1'b0;
        tick(1);
        done   = 1'b0;
        rdData = 16'($urandom);
    endtask

    // Released from reset at this point: POR wait, then the two setup writes.
    task automatic runInit(input string name);
        int n;
        waitWrt({name, " por"}, 300, n);
        checkOutput({name, " por cycles"}, n, 101);
        checkOutput({name, " rdy before init"}, {31'd0, rdy}, 32'd0);
        doTxn({name, " int1_ctrl"}, 16'h0D02, 16'($urandom), 1'b0);
        checkOutput({name, " rdy mid init"}, {31'd0, rdy}, 32'd0);
        doTxn({name, " ctrl2_g"}, 16'h1160, 16'($urandom), 1'b0);
        checkOutput({name, " rdy after init"}, {31'd0, rdy}, 32'd1);
    endtask

    // Sensor raises INT, sequencer reads lo then hi; INT drops with the lo read.
    task automatic applyStimulus(input string name, input logic [7:0] lo, input logic [7:0] hi,
                                 input int expLat);
        int n;
        int v0;
        v0   = vldCount;
        intr = 1'b1;
        waitWrt({name, " int"}, 50, n);
        checkOutput({name, " int latency"}, n, expLat);
        doTxn({name, " rd lo"}, 16'hA600, {8'($urandom), lo}, 1'b1);
        doTxn({name, " rd hi"}, 16'hA700, {8'($urandom), hi}, 1'b0);
        modelSample(lo, hi);
        checkOutput({name, " vld"}, {31'd0, vld}, 32'd1);
        checkOutput({name, " yaw_rt"}, {16'd0, yawRt}, {16'd0, modelYaw});
        tick(1);
        checkOutput({name, " vld width"}, {31'd0, vld}, 32'd0);
        checkOutput({name, " vld count"}, vldCount - v0, 1);
        checkOutput({name, " heading"}, {5'd0, heading}, {5'd0, expHeading()});
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " wrt"}, {31'd0, wrt}, 32'd0);
        checkOutput({name, " cmd"}, {16'd0, cmd}, 32'd0);
        checkOutput({name, " rdy"}, {31'd0, rdy}, 32'd0);
        checkOutput({name, " vld"}, {31'd0, vld}, 32'd0);
        checkOutput({name, " yaw_rt"}, {16'd0, yawRt}, 32'd0);
        checkOutput({name, " heading"}, {5'd0, heading}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] expYaw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int w0;
        int gap;
        logic [7:0] rlo;
        logic [7:0] rhi;

        vecs[0] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[1] = '{8'h03, 8'h00, 16'h0003};
        vecs[2] = '{8'h34, 8'h12, 16'h1234};
        vecs[3] = '{8'h00, 8'h80, 16'h8000};
        vecs[4] = '{8'hFF, 8'h7F, 16'h7FFF};
        vecs[5] = '{8'hA5, 8'h5A, 16'h5AA5};

        intr   = 1'b0;
        done   = 1'b0;
        rdData = 16'h0000;
        rst    = 1'b1;
        modelReset();

        tick(1);
        checkResetState("reset");
        tick(1);
        rst = 1'b0;

        runInit("init");

        w0 = wrtCount;
        tick(50);
        checkOutput("idle no wrt", wrtCount - w0, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, 3);
            checkOutput($sformatf("vec%0d table yaw", i), {16'd0, yawRt}, {16'd0, vecs[i].expYaw});
        end

        // Random gaps with stray done pulses, which the sequencer must ignore while idle.
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 15);
            w0  = wrtCount;
            for (int g = 0; g < gap; g++) begin
                done   = ($urandom_range(0, 3) == 0);
                rdData = 16'($urandom);
                tick(1);
            end
            done = 1'b0;
            checkOutput($sformatf("rnd%0d gap no wrt", i), wrtCount - w0, 0);
            checkOutput($sformatf("rnd%0d gap yaw hold", i), {16'd0, yawRt}, {16'd0, modelYaw});
            rlo = 8'($urandom);
            rhi = 8'($urandom);
            applyStimulus($sformatf("rnd%0d", i), rlo, rhi, 3);
        end

        // Abort a read with reset; INT stays high through the POR wait and setup writes.
        intr = 1'b1;
        waitWrt("abort", 50, n);
        checkOutput("abort rd lo cmd", {16'd0, cmd}, 32'h0000A600);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        modelReset();
        checkResetState("mid-read reset");
        runInit("reinit");
        applyStimulus("pending int", 8'h34, 8'h12, 1);
        checkOutput("pending int yaw", {16'd0, yawRt}, 32'h00001234);

        w0 = wrtCount;
        tick(40);
        checkOutput("final idle no wrt", wrtCount - w0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
